ftdi_tx_arbiter: RTL and testbench
==================================

FTDI_TX_ARBITER -- requirements
Module: ftdi_tx_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4; number of AXI-stream requesters, range 2..8.
REQ-002 SHALL have parameter AXIS_EW, default 1; stream width 8<<AXIS_EW bits, minimum 1 (16 bit).
REQ-003 SHALL have parameter HDR_MAGIC, default 8'hA5; header marker byte.
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous assert, active-high.
REQ-006 Port: en  in  1  1 = new packets may be granted.
REQ-007 Port: s_tvalid  in  N_SRC  per-source valid.
REQ-008 Port: s_tready  out  N_SRC  per-source ready.
REQ-009 Port: s_tdata  in  N_SRC*(8<<AXIS_EW)  packed per-source data, source i in slice i.
REQ-010 Port: s_tkeep  in  N_SRC*(1<<AXIS_EW)  packed per-source byte keep.
REQ-011 Port: s_tlast  in  N_SRC  per-source end of packet.
REQ-012 Port: m_tvalid / m_tready / m_tdata / m_tkeep / m_tlast  out/in/out/out/out  1/1/8<<AXIS_EW/1<<AXIS_EW/1  merged stream to the FTDI 245fifo controller TX port.
REQ-013 Port: busy  out  1  high in HDR or DATA.
REQ-014 Port: pkt_cnt  out  16  packets completed, wraps 16'hFFFF->0.

Function
REQ-015 SHALL implement FSM states IDLE, HDR, DATA.
REQ-016 IDLE: if en=1 and any s_tvalid=1, SHALL latch grant = first requesting index searching rr_ptr, rr_ptr+1, ... mod N_SRC, then enter HDR next cycle.
REQ-017 IDLE: m_tvalid=0, all s_tready=0; en=0 or no request keeps IDLE.
REQ-018 HDR: m_tvalid=1, m_tdata low 16 bits = {HDR_MAGIC, 5'b0, grant[2:0]}, upper bits 0, m_tkeep all ones, m_tlast=0; on m_tready=1 enter DATA.
REQ-019 HDR: header SHALL be held stable while m_tready=0; all s_tready=0.
REQ-020 DATA: m_tvalid/m_tdata/m_tkeep/m_tlast SHALL combinationally equal the granted source; s_tready[grant]=m_tready; all other s_tready=0; zero added latency.
REQ-021 DATA: beat with m_tvalid & m_tready & m_tlast SHALL enter IDLE next cycle, set rr_ptr = (grant+1) mod N_SRC, increment pkt_cnt.
REQ-022 en deasserting in HDR or DATA SHALL NOT abort; current packet completes.
REQ-023 Grant SHALL NOT change between HDR entry and tlast acceptance, regardless of other s_tvalid.
REQ-024 Source dropping s_tvalid mid-packet SHALL stall output (m_tvalid=0), not release grant.
REQ-025 Minimum gap: one IDLE cycle between packets; header costs one beat; no combinational path from s_tvalid to any s_tready.

Reset
REQ-026 On rst: state=IDLE, grant=0, rr_ptr=0, pkt_cnt=0; hence m_tvalid=0, s_tready=0, busy=0.
REQ-027 Reset mid-packet SHALL drop the packet silently; first grant after release searches from index 0.

Structure
REQ-028 Shared package SHALL hold state encoding (IDLE/HDR/DATA) and the header field layout constants (magic position, id width 3).
REQ-029 One sub-module natural: ftdi_rr_pick (combinational round-robin first-set search from pointer, N_SRC requests -> index + found).

Verification
REQ-030 Single source 1, 3-beat packet 0x1111,0x2222,0x3333(last), m_tready=1 -> m_tdata 0xA501,0x1111,0x2222,0x3333, tlast on 4th beat only, pkt_cnt=1.
REQ-031 All 4 sources continuously valid, 1-beat packets -> header ids 0,1,2,3,0 in order.
REQ-032 Source 2 in DATA, source 0 raises valid -> no s_tready[0] until source 2 tlast accepted; next header 0xA500.
REQ-033 m_tready toggling 1/0 every cycle -> no lost or duplicated beats, header held during stalls.
REQ-034 en=0 with sources valid -> m_tvalid stays 0; en dropped during DATA -> packet completes, then IDLE holds.
REQ-035 rst asserted mid-DATA -> outputs 0 asynchronously, pkt_cnt=0; after release, new grant searches from 0.

Source files
------------

// File: rtl/ftdi_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ftdi_tx_arbiter_pkg
// Shared definitions for the FTDI TX arbiter: FSM state encoding, source-id
// type, header field layout and small index/header helpers.
// ---------------------------------------------------------------------------
package ftdi_tx_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Source id field is 3 bits wide, so at most 8 requesters
    localparam int ID_W          = 3;
    localparam int MAX_SRC       = 1 << ID_W;

    // Header word layout: {magic[7:0], 5'b0, id[2:0]}
    localparam int HDR_W         = 16;
    localparam int HDR_MAGIC_W   = 8;
    localparam int HDR_MAGIC_LSB = 8;

    typedef logic [ID_W-1:0] src_id_t;

    // Build the 16-bit header word for a granted source
    function automatic logic [HDR_W-1:0] make_hdr(input logic [HDR_MAGIC_W-1:0] magic,
                                                  input src_id_t                 id);
        logic [HDR_W-1:0] hdr;
        hdr                                    = '0;
        hdr[HDR_MAGIC_LSB +: HDR_MAGIC_W]      = magic;
        hdr[ID_W-1:0]                          = id;
        return hdr;
    endfunction

    // (idx + 1) mod n, for idx already in 0..n-1
    function automatic src_id_t next_idx(input src_id_t idx, input int n);
        return (int'(idx) == n - 1) ? '0 : src_id_t'(idx + 1'b1);
    endfunction

endpackage

// File: rtl/ftdi_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// ftdi_tx_arbiter_if
// Bundles the N_SRC upstream AXI-stream requesters and the merged downstream
// stream toward the FTDI 245fifo TX port.
//   s_tvalid/s_tready/s_tlast : per-source handshake + end of packet
//   s_tdata / s_tkeep         : packed per-source payload, source i in slice i
//   m_t*                      : merged output stream
// Modports:
//   slave  - the arbiter's view (consumes s_*, produces m_*)
//   master - the environment's view (produces s_*, consumes m_*)
// ---------------------------------------------------------------------------
interface ftdi_tx_arbiter_if
    import ftdi_tx_arbiter_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int AXIS_EW = 1
);
    localparam int DW = 8 << AXIS_EW;
    localparam int KW = 1 << AXIS_EW;

    logic [N_SRC-1:0]    s_tvalid;
    logic [N_SRC-1:0]    s_tready;
    logic [N_SRC*DW-1:0] s_tdata;
    logic [N_SRC*KW-1:0] s_tkeep;
    logic [N_SRC-1:0]    s_tlast;

    logic                m_tvalid;
    logic                m_tready;
    logic [DW-1:0]       m_tdata;
    logic [KW-1:0]       m_tkeep;
    logic                m_tlast;

    modport slave (
        input  s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast
    );

    modport master (
        output s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast
    );

endinterface

// File: rtl/ftdi_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// ftdi_rr_pick
// Combinational round-robin search: returns the first set request found when
// scanning i_ptr, i_ptr+1, ... (mod N_SRC).
//   i_req   : request vector, one bit per source
//   i_ptr   : search start index (must be < N_SRC)
//   o_idx   : index of the first requester found (0 when none)
//   o_found : at least one request is set
// ---------------------------------------------------------------------------
module ftdi_rr_pick
    import ftdi_tx_arbiter_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] i_req,
    input  src_id_t          i_ptr,
    output src_id_t          o_idx,
    output logic             o_found
);

    // Padding to the full id range lets a 3-bit index select without
    // running past the end of the request vector.
    logic [MAX_SRC-1:0] w_req_pad;
    assign w_req_pad = MAX_SRC'(i_req);

    always_comb begin
        int pos;
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        o_idx   = '0;
        o_found = 1'b0;
        pos     = 0;
        for (int off = 0; off < N_SRC; off++) begin
            // i_ptr < N_SRC, so one wrap subtraction is enough
            pos = int'(i_ptr) + off;
            if (pos >= N_SRC) begin
                pos = pos - N_SRC;
            end
            if (!o_found && w_req_pad[src_id_t'(pos)]) begin
                o_idx   = src_id_t'(pos);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ftdi_tx_arbiter
// Merges N_SRC AXI-stream packet sources into one stream for the FTDI
// 245fifo TX port. Each packet is prefixed by a one-beat header
// {HDR_MAGIC, 5'b0, id[2:0]}; sources are granted round-robin and a grant is
// held until that source's tlast beat is accepted.
//   clk     : single clock, rising edge
//   rst     : asynchronous active-high reset (drops any packet in flight)
//   en      : 1 = new packets may be granted (never aborts a packet)
//   axis    : source and merged streams (slave modport)
//   busy    : high while in HDR or DATA
//   pkt_cnt : completed packet count, wraps
// ---------------------------------------------------------------------------
module ftdi_tx_arbiter
    import ftdi_tx_arbiter_pkg::*;
#(
    parameter int         N_SRC     = 4,
    parameter int         AXIS_EW   = 1,
    parameter logic [7:0] HDR_MAGIC = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    ftdi_tx_arbiter_if.slave      axis,
    output logic                  busy,
    output logic [15:0]           pkt_cnt
);

    localparam int DW = 8 << AXIS_EW;
    localparam int KW = 1 << AXIS_EW;

    state_t        r_state;
    src_id_t       r_grant;
    src_id_t       r_rr_ptr;
    logic [15:0]   r_pkt_cnt;
    logic          r_busy;

    src_id_t       w_pick_idx;
    logic          w_pick_found;
    logic          w_last_acc;

    // Per-source views padded to MAX_SRC entries so r_grant indexes exactly
    logic [MAX_SRC-1:0] w_valid_pad;
    logic [MAX_SRC-1:0] w_last_pad;
    logic [MAX_SRC-1:0] w_ready_pad;
    logic [DW-1:0]      w_data_pad [MAX_SRC];
    logic [KW-1:0]      w_keep_pad [MAX_SRC];

    assign w_valid_pad = MAX_SRC'(axis.s_tvalid);
    assign w_last_pad  = MAX_SRC'(axis.s_tlast);

    for (genvar i = 0; i < MAX_SRC; i++) begin : g_pad
        if (i < N_SRC) begin : g_src
            assign w_data_pad[i] = axis.s_tdata[i*DW +: DW];
            assign w_keep_pad[i] = axis.s_tkeep[i*KW +: KW];
        end else begin : g_none
            assign w_data_pad[i] = '0;
            assign w_keep_pad[i] = '0;
        end
    end

    ftdi_rr_pick #(
        .N_SRC   (N_SRC)
    ) u_rr_pick (
        .i_req   (axis.s_tvalid),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    // Output mux: header is generated locally, data is a pure combinational
    // pass-through of the granted source. s_tready depends only on state,
    // grant and m_tready, never on any s_tvalid.
    always_comb begin
        axis.m_tvalid = 1'b0;
        axis.m_tdata  = '0;
        axis.m_tkeep  = '0;
        axis.m_tlast  = 1'b0;
        w_ready_pad   = '0;
        case (r_state)
            ST_HDR: begin
                axis.m_tvalid = 1'b1;
                axis.m_tdata  = DW'(make_hdr(HDR_MAGIC, r_grant));
                axis.m_tkeep  = '1;
            end
            ST_DATA: begin
                axis.m_tvalid        = w_valid_pad[r_grant];
                axis.m_tdata         = w_data_pad[r_grant];
                axis.m_tkeep         = w_keep_pad[r_grant];
                axis.m_tlast         = w_last_pad[r_grant];
                w_ready_pad[r_grant] = axis.m_tready;
            end
            default: ;
        endcase
    end

    assign axis.s_tready = w_ready_pad[N_SRC-1:0];

    assign w_last_acc = (r_state == ST_DATA) && axis.m_tvalid && axis.m_tready
                        && axis.m_tlast;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_pkt_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en && w_pick_found) begin
                        r_grant <= w_pick_idx;
                        r_state <= ST_HDR;
                        r_busy  <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (axis.m_tready) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // en is deliberately ignored here: a packet always completes
                    if (w_last_acc) begin
                        r_state   <= ST_IDLE;
                        r_rr_ptr  <= next_idx(r_grant, N_SRC);
                        r_pkt_cnt <= r_pkt_cnt + 16'd1;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign pkt_cnt = r_pkt_cnt;

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ftdi_tx_arbiter
// Self-checking bench for ftdi_tx_arbiter (N_SRC=4, 16-bit stream).
// Source packets are queued per source; the expected merged stream (headers
// plus beats, in the order the round-robin rules dictate) is queued when the
// stimulus is issued and compared beat by beat as the DUT emits it.
// ---------------------------------------------------------------------------
module tb_ftdi_tx_arbiter;

    localparam int N_SRC   = 4;
    localparam int AXIS_EW = 1;
    localparam int DW      = 16;
    localparam int KW      = 2;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        busy;
    logic [15:0] pkt_cnt;

    ftdi_tx_arbiter_if #(.N_SRC(N_SRC), .AXIS_EW(AXIS_EW)) axis ();

    ftdi_tx_arbiter #(
        .N_SRC     (N_SRC),
        .AXIS_EW   (AXIS_EW),
        .HDR_MAGIC (8'hA5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .axis    (axis),
        .busy    (busy),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    beat_t       src_q [N_SRC][$];
    beat_t       exp_q [$];
    logic        en_drv     = 1'b0;
    logic        rdy_toggle = 1'b0;
    logic [N_SRC-1:0] gap   = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Queue n beats on a source: data d0, d0+step, ...; last beat keep=01
    task automatic push_src(input int src, input int n, input logic [15:0] d0,
                            input logic [15:0] step);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = d0 + 16'(k) * step;
            b.keep = (k == n - 1) ? 2'b01 : 2'b11;
            b.last = (k == n - 1);
            src_q[src].push_back(b);
        end
    endtask

    // Expected merged output for the same packet: header then the beats
    task automatic expect_pkt(input int src, input int n, input logic [15:0] d0,
                              input logic [15:0] step);
        beat_t b;
        b.data = {8'hA5, 5'b0, 3'(src)};
        b.keep = 2'b11;
        b.last = 1'b0;
        exp_q.push_back(b);
        for (int k = 0; k < n; k++) begin
            b.data = d0 + 16'(k) * step;
            b.keep = (k == n - 1) ? 2'b01 : 2'b11;
            b.last = (k == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic clear_q();
        for (int i = 0; i < N_SRC; i++) src_q[i].delete();
        exp_q.delete();
        gap        = '0;
        en_drv     = 1'b0;
        rdy_toggle = 1'b0;
    endtask

    // Called at a falling edge; returns at a falling edge with rst released
    task automatic do_reset();
        #2 rst = 1'b1;
        clear_q();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // Wait (bounded) until every expected beat is seen and the DUT is idle
    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    // Source/sink driver and output monitor
    initial begin
        logic              prev_stall;
        logic [31:0]       prev_sig;
        logic [N_SRC-1:0]  fire_s;
        logic [N_SRC-1:0]  v;
        logic [N_SRC-1:0]  l;
        logic [N_SRC*DW-1:0] d;
        logic [N_SRC*KW-1:0] k;
        beat_t             e;
        prev_stall    = 1'b0;
        prev_sig      = '0;
        axis.s_tvalid = '0;
        axis.s_tdata  = '0;
        axis.s_tkeep  = '0;
        axis.s_tlast  = '0;
        axis.m_tready = 1'b1;
        forever begin
            @(negedge clk);
            fire_s = axis.s_tvalid & axis.s_tready;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_stable", {12'b0, axis.m_tvalid, axis.m_tlast, axis.m_tkeep,
                                          axis.m_tdata}, prev_sig);
                end
                if (axis.m_tvalid && axis.m_tready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", axis.m_tdata, e.data);
                        check("beat_keep", axis.m_tkeep, e.keep);
                        check("beat_last", axis.m_tlast, e.last);
                    end
                end
                prev_stall = axis.m_tvalid && !axis.m_tready;
                prev_sig   = {12'b0, axis.m_tvalid, axis.m_tlast, axis.m_tkeep, axis.m_tdata};
            end
            @(posedge clk);
            #1;
            if (!rst) begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (fire_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                end
            end
            v = '0; l = '0; d = '0; k = '0;
            for (int i = 0; i < N_SRC; i++) begin
                if (src_q[i].size() > 0 && !gap[i]) begin
                    v[i]          = 1'b1;
                    d[i*DW +: DW] = src_q[i][0].data;
                    k[i*KW +: KW] = src_q[i][0].keep;
                    l[i]          = src_q[i][0].last;
                end
            end
            axis.s_tvalid = v;
            axis.s_tdata  = d;
            axis.s_tkeep  = k;
            axis.s_tlast  = l;
            axis.m_tready = rdy_toggle ? ~axis.m_tready : 1'b1;
            en            = en_drv;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        // Reset state
        check("rst_m_tvalid", axis.m_tvalid, 0);
        check("rst_s_tready", axis.s_tready, 0);
        check("rst_busy",     busy,          0);
        check("rst_pkt_cnt",  pkt_cnt,       0);
        #2 rst = 1'b0;
        @(negedge clk);

        // Single source 1, three beats
        en_drv = 1'b1;
        expect_pkt(1, 3, 16'h1111, 16'h1111);
        push_src(1, 3, 16'h1111, 16'h1111);
        drain(60);
        check("t1_pkt_cnt", pkt_cnt, 1);
        check("t1_busy",    busy,    0);

        // All sources valid, 1-beat packets: ids 0,1,2,3,0; en=0 holds off
        do_reset();
        push_src(0, 1, 16'h0A00, 16'h0);
        push_src(0, 1, 16'h0A01, 16'h0);
        push_src(1, 1, 16'h1B00, 16'h0);
        push_src(2, 1, 16'h2C00, 16'h0);
        push_src(3, 1, 16'h3D00, 16'h0);
        expect_pkt(0, 1, 16'h0A00, 16'h0);
        expect_pkt(1, 1, 16'h1B00, 16'h0);
        expect_pkt(2, 1, 16'h2C00, 16'h0);
        expect_pkt(3, 1, 16'h3D00, 16'h0);
        expect_pkt(0, 1, 16'h0A01, 16'h0);
        repeat (4) begin
            @(negedge clk);
            check("en_off_tvalid", axis.m_tvalid, 0);
        end
        en_drv = 1'b1;
        drain(120);
        check("t2_pkt_cnt", pkt_cnt, 5);

        // Source 2 holds the grant while source 0 waits
        do_reset();
        en_drv = 1'b1;
        expect_pkt(2, 6, 16'h2000, 16'h0101);
        push_src(2, 6, 16'h2000, 16'h0101);
        repeat (4) @(negedge clk);
        expect_pkt(0, 1, 16'h0F0F, 16'h0);
        push_src(0, 1, 16'h0F0F, 16'h0);
        n = 0;
        while (src_q[2].size() != 0 && n < 60) begin
            check("t3_no_rdy0", axis.s_tready[0], 0);
            @(negedge clk);
            n++;
        end
        drain(60);
        check("t3_pkt_cnt", pkt_cnt, 2);

        // m_tready toggling every cycle
        do_reset();
        en_drv     = 1'b1;
        rdy_toggle = 1'b1;
        expect_pkt(1, 2, 16'h4100, 16'h0011);
        expect_pkt(3, 5, 16'h4300, 16'h0033);
        push_src(3, 5, 16'h4300, 16'h0033);
        push_src(1, 2, 16'h4100, 16'h0011);
        drain(200);
        check("t4_pkt_cnt", pkt_cnt, 2);

        // en dropped mid-DATA: packet completes, then IDLE holds
        do_reset();
        en_drv = 1'b1;
        expect_pkt(0, 6, 16'h5000, 16'h0001);
        push_src(0, 6, 16'h5000, 16'h0001);
        repeat (4) @(negedge clk);
        en_drv = 1'b0;
        push_src(1, 2, 16'h5100, 16'h0001);
        drain(100);
        repeat (4) begin
            @(negedge clk);
            check("t5_idle_tvalid", axis.m_tvalid, 0);
        end
        check("t5_busy",    busy,    0);
        check("t5_pkt_cnt", pkt_cnt, 1);

        // Source drops valid mid-packet: output stalls, grant kept
        do_reset();
        en_drv = 1'b1;
        expect_pkt(2, 4, 16'h6000, 16'h0002);
        push_src(2, 4, 16'h6000, 16'h0002);
        repeat (4) @(negedge clk);
        gap[2] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t6_gap_tvalid", axis.m_tvalid, 0);
            check("t6_gap_busy",   busy,          1);
        end
        gap[2] = 1'b0;
        drain(60);
        check("t6_pkt_cnt", pkt_cnt, 1);

        // Reset mid-DATA, then the first grant searches from index 0
        do_reset();
        en_drv = 1'b1;
        expect_pkt(1, 1, 16'h7100, 16'h0);
        push_src(1, 1, 16'h7100, 16'h0);
        drain(60);
        check("t7_pre_cnt", pkt_cnt, 1);
        expect_pkt(2, 8, 16'h7200, 16'h0001);
        push_src(2, 8, 16'h7200, 16'h0001);
        repeat (5) @(negedge clk);
        check("t7_pre_rdy", axis.s_tready, 4'b0100);
        #2 rst = 1'b1;
        #1;
        check("t7_rst_tvalid", axis.m_tvalid, 0);
        check("t7_rst_tready", axis.s_tready, 0);
        check("t7_rst_busy",   busy,          0);
        check("t7_rst_cnt",    pkt_cnt,       0);
        clear_q();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        en_drv = 1'b1;
        expect_pkt(1, 1, 16'h7A00, 16'h0);
        expect_pkt(3, 1, 16'h7B00, 16'h0);
        push_src(3, 1, 16'h7B00, 16'h0);
        push_src(1, 1, 16'h7A00, 16'h0);
        drain(60);
        check("t7_post_cnt", pkt_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
